// File: rtl/ram_test.sv
// ram_test: single-port synchronous block RAM (default 32K x 16) backing
// the VDC video memory. One address per clock, optional write, unconditional
// read, registered read data with read-before-write on address collisions.
// Optional feature macro: RAM_TEST_OUTREG_EN adds a second output register
// (read latency 2 instead of 1).
module ram_test #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;

  // NOTE: storage is never reset; the declaration initialiser gives the
  // all-zero power-up image, and reset only clears the output pipeline.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_q;

  // Read register and write port; both are blocked while reset is asserted.
  // NOTE: non-blocking assignments make the read sample the old word when
  // the same address is written on the same edge (read-before-write).
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[address];
      // An X/Z wren evaluates false, so no address is disturbed.
      if (wren) begin
        mem[address] <= data;
      end
    end
  end

`ifdef RAM_TEST_OUTREG_EN
  logic [DATA_W-1:0] out_q;

  // Second output stage for timing closure; latency becomes 2.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign q = out_q;
`else
  assign q = rd_q;
`endif

endmodule

// File: tb/tb_ram_test.sv
// Self-checking bench for ram_test: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural memory model with
// a read-history queue for the configured latency.
module tb_ram_test;

`ifdef RAM_TEST_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic [14:0] address = '0;
  logic [15:0] data = '0;
  logic        wren = 1'b0;
  logic [15:0] q;

  int passed = 0;
  int total  = 0;

  logic [15:0] model_mem [0:32767];
  logic [15:0] hist [$];

  ram_test #(.ADDR_W(15), .DATA_W(16)) dut (
    .clock   (clock),
    .reset_N (reset_N),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reads in flight are lost on reset: q shows zero for LAT edges.
  task automatic clear_hist();
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(16'h0000);
  endtask

  // One clock: drive inputs, apply the edge to the model, check q.
  task automatic step(input string tag, input logic [14:0] a,
                      input logic [15:0] d, input logic we);
    address = a;
    data    = d;
    wren    = we;
    @(posedge clock);
    if (reset_N) begin
      hist.push_front(model_mem[a]);
      if (we) model_mem[a] = d;
    end else begin
      clear_hist();
    end
    while (hist.size() > LAT) void'(hist.pop_back());
    #1;
    check(tag, q, hist[LAT-1]);
  endtask

  // Read an address until its data reaches q, then compare to a constant.
  task automatic read_const(input string tag, input logic [14:0] a, input logic [15:0] e);
    for (int i = 0; i < LAT; i++) step(tag, a, 16'h0000, 1'b0);
    check(tag, q, e);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) model_mem[i] = 16'h0000;
    clear_hist();

    // Reset state.
    #12;
    check("reset_q", q, 16'h0000);
    step("in_reset", 15'h0000, 16'h0000, 1'b0);
    #3 reset_N = 1'b1;

    // Power-up contents.
    read_const("pwr_0000", 15'h0000, 16'h0000);
    read_const("pwr_1234", 15'h1234, 16'h0000);
    read_const("pwr_7fff", 15'h7FFF, 16'h0000);

    // Write then read.
    step("wr_0010", 15'h0010, 16'hBEEF, 1'b1);
    step("wr_7fff", 15'h7FFF, 16'h1234, 1'b1);
    read_const("rd_0010", 15'h0010, 16'hBEEF);
    read_const("rd_7fff", 15'h7FFF, 16'h1234);

    // Read during write returns the old word.
    step("rdw_init", 15'h0020, 16'h1111, 1'b1);
    step("rdw_same", 15'h0020, 16'h2222, 1'b1);
    for (int i = 1; i < LAT; i++) step("rdw_flush", 15'h0020, 16'h0000, 1'b0);
    check("rdw_old", q, 16'h1111);
    read_const("rdw_new", 15'h0020, 16'h2222);

    // Asynchronous reset between edges, storage retained.
    read_const("pre_rst", 15'h0010, 16'hBEEF);
    #2 reset_N = 1'b0;
    #1;
    clear_hist();
    check("async_rst", q, 16'h0000);
    step("rst_hold", 15'h0010, 16'h0000, 1'b0);
    #3 reset_N = 1'b1;
    read_const("retained", 15'h0010, 16'hBEEF);

    // Writes while in reset are dropped.
    #2 reset_N = 1'b0;
    for (int i = 0; i < 3; i++) step("wr_in_rst", 15'h0030, 16'hAAAA, 1'b1);
    #3 reset_N = 1'b1;
    read_const("no_wr_rst", 15'h0030, 16'h0000);

    // Streaming write then read, no bubbles.
    for (int i = 0; i < 256; i++)
      step("stream_wr", 15'(i), 16'(i) ^ 16'h5A5A, 1'b1);
    for (int i = 0; i < 256 + LAT; i++)
      step("stream_rd", 15'(i % 256), 16'h0000, 1'b0);
    read_const("stream_ff", 15'h00FF, 16'h00FF ^ 16'h5A5A);

    // Randomized traffic over a small window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [14:0] ra;
      ra = 15'($urandom_range(63));
      if (i % 5 == 0) ra = ra | 15'h7FC0;
      step("random", ra, 16'($urandom), 1'($urandom_range(1)));
    end
    for (int i = 0; i < LAT; i++) step("random_flush", 15'h0000, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
